// File: rtl/audio_clk_pkg.sv
// Shared definitions for the audio clock divider/monitor pair: select codes, monitor states,
// the expected-period table and the period-to-code decoder.
package audio_clk_pkg;

    localparam logic [1:0] FREQ_DIV2  = 2'b00;
    localparam logic [1:0] FREQ_DIV4  = 2'b01;
    localparam logic [1:0] FREQ_DIV8  = 2'b10;
    localparam logic [1:0] FREQ_DIV16 = 2'b11;

    // Indexed by select code: refclk cycles between rising edges of the divided clock.
    localparam int unsigned EXP_PERIOD [4] = '{2, 4, 8, 16};

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Returns {valid, code}; any period outside the table decodes as invalid.
    function automatic logic [2:0] period_to_code(input int unsigned p);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (p == EXP_PERIOD[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_clk_monitor_if.sv
// Monitor-facing bundle: the clock under test going in, measurement and lock status coming out.
// master = clock source / status consumer, slave = the monitor.
interface audio_clk_monitor_if #(
    parameter int CNT_W = 6
);
    logic             audio_clk_in;
    logic [1:0]       freq_code;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             mismatch;
    logic             clock_lost;

    modport master (
        output audio_clk_in,
        input  freq_code, locked, period, meas_valid, mismatch, clock_lost
    );

    modport slave (
        input  audio_clk_in,
        output freq_code, locked, period, meas_valid, mismatch, clock_lost
    );
endinterface

// File: rtl/audio_clk_monitor_edge_detect.sv
// Registers audio_clk_in and emits a one-cycle rise pulse; AUDIO_CLK_MONITOR_SYNC_EN adds a
// 2-flop synchronizer in front. Rise is combinational off the registers (1 or 3 cycles in), no backpressure.
module clk_edge_detect (
    input  logic refclk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic sample;
    logic clk_q;
    logic clk_qd;

`ifdef AUDIO_CLK_MONITOR_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], din};
    end

    assign sample = sync[1];
`else
    assign sample = din;
`endif

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            clk_q  <= 1'b0;
            clk_qd <= 1'b0;
        end else begin
            clk_q  <= sample;
            clk_qd <= clk_q;
        end
    end

    assign rise = clk_q & ~clk_qd;

endmodule

// File: rtl/audio_clk_monitor.sv
// Measures rising-edge spacing of audio_clk_in, decodes the divider code and tracks lock/loss.
// Latency 2 cycles edge->meas_valid (4 with AUDIO_CLK_MONITOR_SYNC_EN); status only, no backpressure.
module audio_clk_monitor
    import audio_clk_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic              refclk,
    input  logic              rst,
    audio_clk_monitor_if.slave mon
);
    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);

    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dec;
    state_t           state;
    logic [1:0]       cand;
    logic [MC_W-1:0]  mcnt;

    logic [1:0]       freq_code;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             mismatch;
    logic             clock_lost;

    clk_edge_detect u_edge (
        .refclk (refclk),
        .rst    (rst),
        .din    (mon.audio_clk_in),
        .rise   (rise)
    );

    assign dec = period_to_code(32'(cnt));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            cnt        <= '0;
            cand       <= FREQ_DIV2;
            mcnt       <= '0;
            freq_code  <= FREQ_DIV2;
            locked     <= 1'b0;
            period     <= '0;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            clock_lost <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;

            if (rise)                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

            // An edge landing on the saturated count is still a measurement, not a loss.
            if (!rise && cnt == CNT_MAX) begin
                state      <= SEARCH;
                locked     <= 1'b0;
                clock_lost <= 1'b1;
                mcnt       <= '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (rise) begin
                            state      <= MEASURE;
                            clock_lost <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period     <= cnt;
                            meas_valid <= 1'b1;
                            if (!dec[2]) begin
                                mcnt <= '0;
                            end else if (dec[1:0] == cand) begin
                                mcnt <= mcnt + 1'b1;
                            end else begin
                                cand <= dec[1:0];
                                mcnt <= MC_W'(1);
                            end
                        end else if (mcnt == MC_LOCK) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            freq_code <= cand;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period     <= cnt;
                            meas_valid <= 1'b1;
                            if (!(dec[2] && dec[1:0] == cand)) begin
                                state    <= MEASURE;
                                locked   <= 1'b0;
                                mismatch <= 1'b1;
                                if (dec[2]) begin
                                    cand <= dec[1:0];
                                    mcnt <= MC_W'(1);
                                end else begin
                                    mcnt <= '0;
                                end
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign mon.freq_code  = freq_code;
    assign mon.locked     = locked;
    assign mon.period     = period;
    assign mon.meas_valid = meas_valid;
    assign mon.mismatch   = mismatch;
    assign mon.clock_lost = clock_lost;

endmodule
